fp16_frame_sequencer: RTL and testbench

- Frame-level controller for the serial FP16 add/sub path: SIPO (32-bit input) -> FP16 pipelined adder -> PISO (16-bit output).
- Counts incoming serial bits and gates the SIPO shift enable.
- Launches the adder, waits for its ready with a timeout, loads the PISO, then frames the 16 serial result bits.
- Reports per-frame completion, a timeout error and a completed-frame count.

---
 rtl/fp16_frame_sequencer.sv | 145 ++++++++++++++
 tb/tb_fp16_frame_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_frame_sequencer.sv
// Frame controller for the serial FP16 add/sub path: gates SIPO shifting, launches the
// adder, waits for its result with a timeout, then frames the serial result via the PISO.
module fp16_frame_sequencer #(
  parameter int IN_BITS  = 32,
  parameter int OUT_BITS = 16,
  parameter int MIN_LAT  = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       abort,
  input  logic       sum_ready,
  output logic       sipo_en,
  output logic       sum_en,
  output logic       piso_load,
  output logic       out_valid,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic [7:0] frame_cnt
);

  localparam int IC_W = $clog2(IN_BITS + 1);
  localparam int OC_W = $clog2(OUT_BITS + 1);
  localparam int W_W  = $clog2(TIMEOUT + 1);

  localparam logic [IC_W-1:0] IN_LAST  = IC_W'(IN_BITS - 1);
  localparam logic [OC_W-1:0] OUT_LAST = OC_W'(OUT_BITS - 1);
  localparam logic [W_W-1:0]  W_MIN    = W_W'(MIN_LAT);
  localparam logic [W_W-1:0]  W_TO     = W_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, SHIFT_IN, COMPUTE, WAIT_READY, LOAD_OUT, SHIFT_OUT, DONE_S
  } state_t;

  state_t          state, state_n;
  logic [IC_W-1:0] in_cnt, in_cnt_n;
  logic [OC_W-1:0] out_cnt, out_cnt_n;
  logic [W_W-1:0]  w, w_n;
  logic            err_n;
  logic [7:0]      fc_n;

  // Shift enable stays combinational so the SIPO captures the bit in the same cycle.
  assign sipo_en = in_valid & ~rst & ((state == IDLE) | (state == SHIFT_IN));

  always_comb begin
    state_n   = state;
    in_cnt_n  = in_cnt;
    out_cnt_n = out_cnt;
    w_n       = w;
    err_n     = timeout_err;
    fc_n      = frame_cnt;
    if (abort && (state != IDLE)) begin
      state_n   = IDLE;
      in_cnt_n  = '0;
      out_cnt_n = '0;
      w_n       = '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_cnt_n = IC_W'(1);
            err_n    = 1'b0;
            state_n  = SHIFT_IN;
          end
        end
        SHIFT_IN: begin
          if (in_valid) begin
            if (in_cnt == IN_LAST) begin
              in_cnt_n = '0;
              state_n  = COMPUTE;
            end else begin
              in_cnt_n = in_cnt + IC_W'(1);
            end
          end
        end
        COMPUTE: begin
          w_n     = '0;
          state_n = WAIT_READY;
        end
        WAIT_READY: begin
          // Early ready is ignored: it may still be the previous operation's level.
          if (sum_ready && (w >= W_MIN)) begin
            w_n     = '0;
            state_n = LOAD_OUT;
          end else if (w == W_TO) begin
            w_n     = '0;
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            w_n = w + W_W'(1);
          end
        end
        LOAD_OUT: begin
          out_cnt_n = '0;
          state_n   = SHIFT_OUT;
        end
        SHIFT_OUT: begin
          if (out_cnt == OUT_LAST) begin
            out_cnt_n = '0;
            state_n   = DONE_S;
          end else begin
            out_cnt_n = out_cnt + OC_W'(1);
          end
        end
        DONE_S: begin
          fc_n    = frame_cnt + 8'd1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      w           <= '0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
      sum_en      <= 1'b0;
      piso_load   <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      in_cnt      <= in_cnt_n;
      out_cnt     <= out_cnt_n;
      w           <= w_n;
      timeout_err <= err_n;
      frame_cnt   <= fc_n;
      sum_en      <= (state_n == COMPUTE);
      piso_load   <= (state_n == LOAD_OUT);
      out_valid   <= (state_n == SHIFT_OUT);
      busy        <= (state_n != IDLE);
      done        <= (state_n == DONE_S);
    end
  end

endmodule

// File: tb/tb_fp16_frame_sequencer.sv
// Bench for fp16_frame_sequencer: behavioural SIPO, FP16 adder and PISO around the DUT,
// with a scoreboard of expected serial results and frame counts.
module tb_fp16_frame_sequencer;

  localparam int IN_BITS  = 32;
  localparam int OUT_BITS = 16;
  localparam int MIN_LAT  = 1;
  localparam int TIMEOUT  = 15;

  localparam int MODE_NORM  = 0;
  localparam int MODE_STALE = 1;
  localparam int MODE_ZERO  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       abort = 1'b0;
  logic       sum_ready = 1'b0;
  logic       serial_in = 1'b0;
  logic       sipo_en, sum_en, piso_load, out_valid, busy, done, timeout_err;
  logic [7:0] frame_cnt;

  fp16_frame_sequencer #(
    .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .abort(abort), .sum_ready(sum_ready),
    .sipo_en(sipo_en), .sum_en(sum_en), .piso_load(piso_load), .out_valid(out_valid),
    .busy(busy), .done(done), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [7:0]  fc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          mode = MODE_NORM;
  int          rdy_dly = 0;
  int          bits_acc = 0, sum_en_cnt = 0, load_cnt = 0, ov_cnt = 0, done_cnt = 0;
  int          last_bit_cyc = 0, sum_cyc = 0, load_cyc = 0;
  logic [31:0] sipo = '0;
  logic [15:0] sum_reg = '0, piso = '0, res = '0;
  logic        fc_pending = 1'b0;
  logic [7:0]  fc_exp_pend = '0;
  logic [7:0]  fc_model = '0;

  logic [15:0] tab_x1  [4] = '{16'h3C00, 16'h4400, 16'h4200, 16'hC000};
  logic [15:0] tab_x2  [4] = '{16'h4000, 16'h3800, 16'h4200, 16'h4400};
  logic [15:0] tab_sum [4] = '{16'h4200, 16'h4480, 16'h4600, 16'h4000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r_in);
    real        r;
    logic       s;
    int         e;
    logic [9:0] m;
    r = r_in;
    s = (r < 0.0);
    if (s) r = -r;
    if (r == 0.0) return 16'h0000;
    e = 15;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0) begin r = r * 2.0; e--; end
    m = 10'($rtoi((r - 1.0) * 1024.0));
    return {s, 5'(e), m};
  endfunction

  always @(posedge clk) cyc++;

  // Datapath models and scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (fc_pending) begin
        chk("frame_cnt", frame_cnt, fc_exp_pend);
        fc_pending = 1'b0;
      end
      if (sipo_en) begin
        sipo = {sipo[30:0], serial_in};
        bits_acc++;
        if (bits_acc == IN_BITS) last_bit_cyc = cyc;
      end
      if (rdy_dly > 0) begin
        rdy_dly--;
        if (rdy_dly == 0) sum_ready = 1'b1;
      end
      if (sum_en) begin
        sum_en_cnt++;
        sum_cyc = cyc;
        sum_reg = r2h(h2r(sipo[31:16]) + h2r(sipo[15:0]));
        if (mode == MODE_STALE) sum_ready = 1'b1;
        else if (mode == MODE_ZERO) sum_ready = 1'b0;
        else begin
          sum_ready = 1'b0;
          rdy_dly   = 2;
        end
      end
      if (piso_load) begin
        load_cnt++;
        load_cyc = cyc;
        piso = sum_reg;
        res  = '0;
      end
      if (out_valid) begin
        res  = {res[14:0], piso[15]};
        piso = {piso[14:0], 1'b0};
        ov_cnt++;
      end
      if (done) begin
        exp_t e;
        done_cnt++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", res, e.res);
          chk("bits_accepted", bits_acc, IN_BITS);
          chk("sum_en_pulses", sum_en_cnt, 1);
          chk("piso_loads", load_cnt, 1);
          chk("out_valid_cycles", ov_cnt, OUT_BITS);
          fc_pending  = 1'b1;
          fc_exp_pend = e.fc;
        end
      end
    end
  end

  task automatic send_frame(input logic [15:0] x1, input logic [15:0] x2,
                            input logic [15:0] exp_sum, input bit expect_done,
                            input bit stall, input int nbits);
    logic [31:0] word;
    exp_t        e;
    word       = {x1, x2};
    bits_acc   = 0;
    sum_en_cnt = 0;
    load_cnt   = 0;
    ov_cnt     = 0;
    if (expect_done) begin
      fc_model = fc_model + 8'd1;
      e.res    = exp_sum;
      e.fc     = fc_model;
      sb.push_back(e);
    end
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      if (i == 1) chk("err_cleared_by_first_bit", timeout_err, 0);
      in_valid  = 1'b1;
      serial_in = word[31-i];
      if (stall && ((i + 1 == 5) || (i + 1 == 16) || (i + 1 == 31))) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 chk("stall_sipo_en", sipo_en, 0);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 300);
    chk(tag, busy, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int done_before;
    int n;
    logic [7:0] fc_before;

    // Reset state, with in_valid held high to prove sipo_en is gated by rst
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sipo_en", sipo_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum_en", sum_en, 0);
    chk("rst_piso_load", piso_load, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    in_valid = 1'b0;
    rst = 1'b0;

    // Nominal and distinct operand patterns
    for (int i = 0; i < 4; i++) begin
      send_frame(tab_x1[i], tab_x2[i], tab_sum[i], 1'b1, 1'b0, IN_BITS);
      wait_idle("idle_nominal");
    end

    // Stalled input
    send_frame(tab_x1[0], tab_x2[0], tab_sum[0], 1'b1, 1'b1, IN_BITS);
    wait_idle("idle_stall");

    // Stale ready held high throughout
    mode = MODE_STALE;
    sum_ready = 1'b1;
    send_frame(tab_x1[1], tab_x2[1], tab_sum[1], 1'b1, 1'b0, IN_BITS);
    wait_idle("idle_stale");
    chk("stale_load_latency", load_cyc - last_bit_cyc, 3 + MIN_LAT);

    // Timeout
    mode = MODE_ZERO;
    sum_ready = 1'b0;
    done_before = done_cnt;
    fc_before = frame_cnt;
    send_frame(tab_x1[2], tab_x2[2], tab_sum[2], 1'b0, 1'b0, IN_BITS);
    wait_idle("idle_timeout");
    chk("timeout_idle_cycle", cyc - sum_cyc, TIMEOUT + 2);
    chk("timeout_err_set", timeout_err, 1);
    chk("timeout_no_done", done_cnt, done_before);
    chk("timeout_frame_cnt", frame_cnt, fc_before);
    chk("timeout_no_load", load_cnt, 0);
    mode = MODE_NORM;
    send_frame(tab_x1[3], tab_x2[3], tab_sum[3], 1'b1, 1'b0, IN_BITS);
    wait_idle("idle_after_timeout");

    // Abort during the eighth result bit
    done_before = done_cnt;
    fc_before = frame_cnt;
    send_frame(tab_x1[0], tab_x2[0], tab_sum[0], 1'b0, 1'b0, IN_BITS);
    n = 0;
    for (int k = 0; k < 100 && n < 8; k++) begin
      if (out_valid) n++;
      if (n < 8) begin
        @(posedge clk); #1;
      end
    end
    chk("abort_reached_bit7", n, 8);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, done_before);
    chk("abort_frame_cnt", frame_cnt, fc_before);

    // Reset in the middle of the input frame
    send_frame(tab_x1[1], tab_x2[1], tab_sum[1], 1'b0, 1'b0, 20);
    @(posedge clk); #1;
    in_valid = 1'b1;
    #1 chk("pre_rst_sipo_en", sipo_en, 1);
    rst = 1'b1;
    #1;
    chk("midrst_sipo_en", sipo_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    fc_model = '0;
    sum_ready = 1'b0;
    rdy_dly = 0;

    // 256 back-to-back frames wrap the frame counter
    done_before = done_cnt;
    for (int i = 0; i < 256; i++) begin
      send_frame(tab_x1[i%4], tab_x2[i%4], tab_sum[i%4], 1'b1, 1'b0, IN_BITS);
      wait_idle("idle_wrap");
    end
    @(posedge clk); #1;
    chk("wrap_frame_cnt", frame_cnt, 0);
    chk("wrap_done_count", done_cnt - done_before, 256);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
